// File: rtl/sisc_pkg.sv
// ============================================================================
// sisc_pkg : loader state encoding and shared SISC datapath constants
// Rev 1.0
// ============================================================================
`default_nettype none

package sisc_pkg;

    localparam int INSTR_W = 32;
    localparam int BYTE_W  = 8;

    localparam logic [1:0] LANE_FIRST = 2'd0;
    localparam logic [1:0] LANE_LAST  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_FINISH = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader_byte_packer.sv
// ============================================================================
// byte_packer : shifts bytes MSB-first into a 32-bit instruction word
// Rev 1.0
// ============================================================================
`default_nettype none

module byte_packer
    import sisc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_f,
    input  logic               clr,
    input  logic               shift_en,
    input  logic [BYTE_W-1:0]  byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_ready
);

    logic [1:0] lane;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            word <= '0;
            lane <= LANE_FIRST;
        end else if (clr) begin
            word <= '0;
            lane <= LANE_FIRST;
        end else if (shift_en) begin
            word <= {word[INSTR_W-BYTE_W-1:0], byte_in};
            lane <= lane + 2'd1;
        end
    end

    // Asserted in the cycle the fourth byte is being shifted in.
    assign word_ready = shift_en && (lane == LANE_LAST);

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader : byte-stream to instruction-memory loader holding the core in reset
// Rev 1.0
// ============================================================================
`default_nettype none

module prog_loader
    import sisc_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                IM_DEPTH  = 65536,
    parameter int                TIMEOUT   = 1000000
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [ADDR_W-1:0]  im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               im_we,
    output logic               cpu_rst_f,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [15:0]        words_loaded
);

    localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    loader_state_t   state;
    logic [15:0]     len;
    logic [TO_W-1:0] to_cnt;
    logic            xfer;
    logic            waiting;
    logic            start_ok;
    logic            pk_ready;
    logic [15:0]     len_rx;
    logic [15:0]     count_nx;

    assign xfer     = in_valid && in_ready;
    assign waiting  = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA);
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_ERR));
    assign len_rx   = {len[15:8], in_data};
    assign count_nx = words_loaded + 16'd1;

    byte_packer u_packer (
        .clk        (clk),
        .rst_f      (rst_f),
        .clr        (start_ok),
        .shift_en   (xfer && (state == ST_DATA)),
        .byte_in    (in_data),
        .word       (im_wdata),
        .word_ready (pk_ready)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            cpu_rst_f    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            len          <= '0;
            to_cnt       <= '0;
        end else begin
            im_we <= 1'b0;
            done  <= 1'b0;
            if (waiting && !xfer) begin
                // Stalled stream: abort before any partial word is written.
                if (to_cnt == TO_LAST) begin
                    err      <= 1'b1;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                    to_cnt   <= '0;
                    state    <= ST_ERR;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
                case (state)
                    ST_IDLE, ST_ERR: begin
                        if (start_ok) begin
                            err          <= 1'b0;
                            words_loaded <= '0;
                            cpu_rst_f    <= 1'b0;
                            busy         <= 1'b1;
                            in_ready     <= 1'b1;
                            state        <= ST_LEN_HI;
                        end else if (state == ST_IDLE) begin
                            cpu_rst_f <= 1'b1;
                        end
                    end
                    ST_LEN_HI: begin
                        len[15:8] <= in_data;
                        state     <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        len[7:0] <= in_data;
                        if (len_rx == 16'd0) begin
                            done      <= 1'b1;
                            cpu_rst_f <= 1'b1;
                            busy      <= 1'b0;
                            in_ready  <= 1'b0;
                            state     <= ST_FINISH;
                        end else if ({16'd0, len_rx} > 32'(IM_DEPTH)) begin
                            err      <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                            state    <= ST_ERR;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (pk_ready) begin
                            in_ready <= 1'b0;
                            im_we    <= 1'b1;
                            im_addr  <= BASE_ADDR + ADDR_W'(words_loaded);
                            state    <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        words_loaded <= count_nx;
                        if (count_nx == len) begin
                            done      <= 1'b1;
                            cpu_rst_f <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_FINISH;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ST_DATA;
                        end
                    end
                    ST_FINISH: state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader : scoreboard bench for prog_loader (base 0000 and base FFFF)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_f, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, im_we, cpu_rst_f, busy, done, err;
    logic [15:0] im_addr, words_loaded;
    logic [31:0] im_wdata;
    logic        in_ready_w, im_we_w, cpu_rst_f_w, busy_w, done_w, err_w;
    logic [15:0] im_addr_w, words_loaded_w;
    logic [31:0] im_wdata_w;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [47:0] exp_q[$];
    logic [7:0]  stim_q[$];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000), .IM_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_f(rst_f), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .im_addr(im_addr), .im_wdata(im_wdata), .im_we(im_we),
        .cpu_rst_f(cpu_rst_f), .busy(busy), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    prog_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFF), .IM_DEPTH(4), .TIMEOUT(16)) dut_w (
        .clk(clk), .rst_f(rst_f), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_w), .im_addr(im_addr_w), .im_wdata(im_wdata_w), .im_we(im_we_w),
        .cpu_rst_f(cpu_rst_f_w), .busy(busy_w), .done(done_w), .err(err_w),
        .words_loaded(words_loaded_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Both instances see identical stimulus; the second one is offset by FFFF.
    always @(negedge clk) begin
        logic [47:0] e;
        if (rst_f === 1'b1 && (im_we === 1'b1 || im_we_w === 1'b1)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 64'({im_we, im_we_w}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("we_main", 64'({im_we, im_addr, im_wdata}), 64'({1'b1, e}));
                check("we_wrap", 64'({im_we_w, im_addr_w, im_wdata_w}),
                      64'({1'b1, e[47:32] + 16'hFFFF, e[31:0]}));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_all(input int gap);
        for (int i = 0; i < stim_q.size(); i++) begin
            int waited;
            waited   = 0;
            in_data  = stim_q[i];
            in_valid = 1'b1;
            @(negedge clk);
            while (in_ready !== 1'b1 && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            if (in_ready !== 1'b1) begin
                check("ready_wait", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (gap > 0 && i != stim_q.size() - 1) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_finish(input int lat, input int n);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check("done_early", 64'(done), 64'd0);
        end
        @(negedge clk);
        check("finish_flags", 64'({done, cpu_rst_f, busy, err}), 64'(4'b1100));
        check("words_loaded", 64'(words_loaded), 64'(n));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic load_normal(input int gap);
        stim_q = '{8'h00, 8'h02, 8'h10, 8'h12, 8'h00, 8'h01, 8'h20, 8'h23, 8'h00, 8'h05};
        exp_q.push_back({16'h0000, 32'h10120001});
        exp_q.push_back({16'h0001, 32'h20230005});
        in_data  = 8'h00;
        in_valid = 1'b1;
        pulse_start();
        check("busy_start", 64'({busy, cpu_rst_f, err, in_ready}), 64'(4'b1001));
        send_all(gap);
        check_finish(2, 2);
    endtask

    initial begin
        logic [31:0] w;
        rst_f = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", 64'({in_ready, im_we, cpu_rst_f, busy, done, err}), 64'd0);
        check("rst_vals", 64'({im_addr, im_wdata}), 64'd0);
        check("rst_count", 64'(words_loaded), 64'd0);
        rst_f = 1'b1;
        @(negedge clk);
        check("cpu_rst_hold", 64'(cpu_rst_f), 64'd0);
        @(negedge clk);
        check("cpu_rst_rise", 64'(cpu_rst_f), 64'd1);

        // Normal load, start coinciding with a valid byte, then with gaps.
        @(posedge clk); #1;
        load_normal(0);
        load_normal(2);

        // Zero-length program.
        stim_q = '{8'h00, 8'h00};
        pulse_start();
        send_all(0);
        check_finish(1, 0);

        // Stream stalls mid-word.
        stim_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        pulse_start();
        send_all(0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("timeout_early", 64'(err), 64'd0);
        @(negedge clk);
        check("timeout_err", 64'({err, busy, cpu_rst_f, in_ready}), 64'(4'b1000));
        repeat (3) @(negedge clk);
        check("err_sticky", 64'({err, cpu_rst_f}), 64'(2'b10));
        @(posedge clk); #1;
        load_normal(0);

        // Oversize header.
        stim_q = '{8'h00, 8'h05};
        pulse_start();
        send_all(0);
        @(negedge clk);
        check("oversize_err", 64'({err, busy, cpu_rst_f, in_ready}), 64'(4'b1000));

        // Exactly IM_DEPTH words.
        stim_q = '{8'h00, 8'h04};
        for (int i = 0; i < 4; i++) begin
            w = {8'(8'hA0 + i), 8'h5A, 8'(i * 3), 8'(8'hF0 - i)};
            stim_q.push_back(w[31:24]);
            stim_q.push_back(w[23:16]);
            stim_q.push_back(w[15:8]);
            stim_q.push_back(w[7:0]);
            exp_q.push_back({16'(i), w});
        end
        pulse_start();
        check("err_clear", 64'(err), 64'd0);
        send_all(1);
        check_finish(2, 4);

        // Asynchronous reset in the middle of a word.
        stim_q = '{8'h00, 8'h02, 8'h10, 8'h12};
        pulse_start();
        send_all(0);
        #1 rst_f = 1'b0;
        #1;
        check("arst_flags", 64'({in_ready, im_we, cpu_rst_f, busy, done, err}), 64'd0);
        check("arst_vals", 64'({im_addr, im_wdata}), 64'd0);
        check("arst_count", 64'(words_loaded), 64'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst_f = 1'b1;
        @(negedge clk);
        check("arst_start_ignored", 64'({busy, in_ready, cpu_rst_f}), 64'd0);
        @(negedge clk);
        check("arst_cpu_release", 64'({busy, cpu_rst_f}), 64'(2'b01));
        @(posedge clk); #1;
        load_normal(0);

        check("leftover", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the SISC instruction-memory interface: accepts a byte stream over a valid/ready handshake and packs it into 32-bit instruction words.
- Writes each word into instruction memory at consecutive addresses.
- Holds the processor core in reset (cpu_rst_f low) while loading and releases it only after a complete, error-free load.
- Sits between the host/serial front end and the im write port, alongside the sisc core.

Parameters:
- ADDR_W, 16, instruction memory address width (matches pc width)
- BASE_ADDR, 16'h0000, address of the first loaded word
- IM_DEPTH, 65536, maximum number of words accepted; larger length headers are rejected
- TIMEOUT, 1000000, clk cycles allowed between accepted bytes before abort

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_f  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse that begins a load; ignored while busy
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a byte this cycle
- im_addr  output  ADDR_W  instruction memory write address
- im_wdata  output  32  instruction word to write
- im_we  output  1  instruction memory write strobe, one cycle per word
- cpu_rst_f  output  1  active-low reset to sisc core
- busy  output  1  load in progress
- done  output  1  one-cycle pulse on successful completion
- err  output  1  sticky error flag, cleared by the next start
- words_loaded  output  16  count of words written in the current or last load

Behaviour:
- Reset values (async, rst_f low): state IDLE; in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rst_f=0, busy=0, done=0, err=0, words_loaded=0, timeout counter=0.
- cpu_rst_f is registered. It goes 1 on the first clk edge in IDLE after rst_f deasserts.
- Transfer rule: a byte is consumed on a rising edge where in_valid && in_ready. in_data must be held while in_valid && !in_ready.
- Stream format: 2-byte word count N (big-endian: high byte first), then N*4 data bytes. Each word is MSB first, so byte0 goes to [31:24] and byte3 to [7:0].
- States:
  - IDLE: in_ready=0. On start: err<=0, words_loaded<=0, cpu_rst_f<=0, busy<=1, go to LEN_HI.
  - LEN_HI: in_ready=1. On transfer: N[15:8]<=in_data, go to LEN_LO.
  - LEN_LO: in_ready=1. On transfer: N[7:0]<=in_data.
    - If N==0: go to FINISH.
    - If N>IM_DEPTH: go to ERR.
    - Otherwise: go to DATA with lane=0.
  - DATA: in_ready=1. On each transfer, shift the byte into the word register and increment lane. On the 4th byte, go to WRITE.
  - WRITE: in_ready=0, im_we=1 for exactly one cycle.
    - im_addr = BASE_ADDR + words_loaded, mod 2^ADDR_W (wrap-around permitted).
    - im_wdata = assembled word.
    - Next edge: words_loaded++. If the new words_loaded==N go to FINISH, else go to DATA.
  - FINISH: done=1 for one cycle, cpu_rst_f<=1, busy<=0, go to IDLE.
  - ERR: err=1, busy=0, cpu_rst_f held 0 so a partial program is never run. On start: restart as from IDLE.
- Timeout: the counter clears on every transfer and on state entry. It increments each cycle in LEN_HI, LEN_LO and DATA without a transfer. When it reaches TIMEOUT-1, go to ERR; no im_we is issued for a partial word.
- start while busy is ignored. start and a transfer in the same cycle while in IDLE: the byte is not consumed, because in_ready=0.
- rst_f asserted mid-load: immediate return to reset values. Words already written stay in memory; cpu_rst_f=0.
- Latency: the last data byte is accepted at edge k, im_we is high during cycle k+1, and done is high during cycle k+2.

Decomposition:
- Shared package (sisc_pkg), containing:
  - loader state encoding: IDLE, LEN_HI, LEN_LO, DATA, WRITE, FINISH, ERR
  - byte-lane constants
  - the 32-bit instruction width constant, shared with ir and im
- One sub-module, byte_packer: 8-to-32 shift assembler with a 2-bit lane counter and word_ready output. Cleared on start.
- The timeout counter stays inline.

Test Plan:
- Normal load: start, stream 00 02 | 10 12 00 01 | 20 23 00 05, in_valid always high → im_we exactly twice: addr 0000 data 10120001, then addr 0001 data 20230005. done pulses 2 cycles after the last byte; cpu_rst_f rises with done; words_loaded=2.
- Backpressure and gaps: same stream with in_valid toggling 1,0,0,1 and data held while in_ready=0 → identical writes; no byte consumed twice or dropped.
- Zero length: stream 00 00 → no im_we; done pulses; cpu_rst_f=1.
- Timeout: TIMEOUT=16, send 00 01 AA BB then stop → ERR after 16 idle cycles; err=1, no im_we, cpu_rst_f=0. A following start plus a valid stream clears err and loads correctly.
- Oversize and wrap: IM_DEPTH=4, header 00 05 → ERR right after LEN_LO. With BASE_ADDR=FFFF and N=2, the writes go to FFFF then 0000.
- Async reset mid-load: drop rst_f during DATA → all outputs return to reset values with no clock edge; start is ignored until rst_f is released.
